bubble_buffer_loader: RTL

BUBBLE_BUFFER_LOADER -- requirements
Module: bubble_buffer_loader

---
 rtl/bubble_buffer_loader_if.sv | 49 ++++
 rtl/bubble_buffer_loader.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/bubble_buffer_loader_if.sv
// ----------------------------------------------------------------------------
// bubble_buffer_loader_if
//
// Purpose: groups the load-control, byte-stream and buffer-write signals of
// the bubble buffer loader into one bundle.
//
// Signals:
//   LOADSTART  load request (sampled on the MCLK rising edge)
//   ACCTYPE    load type, 3'b110 = BOOT, 3'b111 = USER
//   BYTEDATA   image byte from the upstream source
//   BYTEVALID  BYTEDATA is valid
//   BYTEREADY  loader accepts a byte this cycle
//   BUFWADDR   buffer bit address (bit0 = channel, bits[13:1] = word)
//   BUFWCLK    buffer write strobe, write on its rising edge
//   BUFWDATA   buffer write data bit
//   LOADBUSY   a load is in progress
//   LOADDONE   one-cycle pulse when a load completes
//
// Modports:
//   master  the upstream controller / byte source and buffer
//   slave   the loader itself
//
// Byte handshake: a byte transfers on every MCLK rising edge where both
// BYTEVALID and BYTEREADY are 1. The source keeps BYTEDATA stable while
// BYTEVALID is 1 and BYTEREADY is 0; BYTEREADY never depends on BYTEVALID
// combinationally.
// ----------------------------------------------------------------------------
interface bubble_buffer_loader_if;
    logic        LOADSTART;
    logic [2:0]  ACCTYPE;
    logic [7:0]  BYTEDATA;
    logic        BYTEVALID;
    logic        BYTEREADY;
    logic [14:0] BUFWADDR;
    logic        BUFWCLK;
    logic        BUFWDATA;
    logic        LOADBUSY;
    logic        LOADDONE;

    modport master (
        output LOADSTART, ACCTYPE, BYTEDATA, BYTEVALID,
        input  BYTEREADY, BUFWADDR, BUFWCLK, BUFWDATA, LOADBUSY, LOADDONE
    );

    modport slave (
        input  LOADSTART, ACCTYPE, BYTEDATA, BYTEVALID,
        output BYTEREADY, BUFWADDR, BUFWCLK, BUFWDATA, LOADBUSY, LOADDONE
    );
endinterface

// File: rtl/bubble_buffer_loader.sv
// ----------------------------------------------------------------------------
// bubble_buffer_loader
//
// Purpose: loads a boot or user image, delivered one byte at a time, into a
// bit-addressed bubble buffer. A BOOT load first writes a 65-bit sync pattern
// (64 zeros then a one on the even channel), then both load types serialise
// every byte LSB first into consecutive bit addresses. Each bit write takes
// two cycles: address/data change with the strobe low (cycle A), then the
// strobe goes high with address/data held (cycle B).
//
// Ports:
//   MCLK       system clock (48 MHz), the only clock
//   RESET      synchronous, active-high reset
//   bus        bubble_buffer_loader_if.slave bundle (see interface header)
//   fsm_state  debug view of the FSM state:
//              0 = IDLE, 1 = SYNC, 2 = WAITBYTE, 3 = SHIFT, 4 = DONE
// ----------------------------------------------------------------------------
module bubble_buffer_loader (
    input  logic                         MCLK,
    input  logic                         RESET,
    bubble_buffer_loader_if.slave        bus,
    output logic [2:0]                   fsm_state
);

    localparam logic [2:0]  ACC_BOOT        = 3'b110;
    localparam logic [2:0]  ACC_USER        = 3'b111;
    localparam logic [14:0] SYNC_FIRST_ADDR = 15'd3974;   // word 1987, D0
    localparam logic [6:0]  SYNC_LAST       = 7'd64;      // 65 sync writes: 0..64
    localparam logic [14:0] BOOT_BASE       = 15'd4106;   // word 2053
    localparam logic [14:0] USER_BASE       = 15'd14342;  // word 7171
    localparam logic [8:0]  BOOT_BYTES      = 9'd480;
    localparam logic [8:0]  USER_BYTES      = 9'd128;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SYNC     = 3'd1,
        ST_WAITBYTE = 3'd2,
        ST_SHIFT    = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

    state_t      state, state_n;

    logic        wphase, wphase_n;     // 0: write cycle A, 1: write cycle B
    logic [14:0] waddr, waddr_n;
    logic        wdata, wdata_n;
    logic        wclk, wclk_n;
    logic [7:0]  shreg, shreg_n;
    logic [2:0]  bitcnt, bitcnt_n;
    logic [8:0]  bytecnt, bytecnt_n;
    logic [6:0]  synccnt, synccnt_n;
    logic [2:0]  acc, acc_n;

    logic        start_boot;
    logic        start_user;
    logic        last_byte;
    logic [14:0] base_addr;

    assign start_boot = bus.LOADSTART && (bus.ACCTYPE == ACC_BOOT);
    assign start_user = bus.LOADSTART && (bus.ACCTYPE == ACC_USER);
    assign base_addr  = (acc == ACC_BOOT) ? BOOT_BASE : USER_BASE;
    assign last_byte  = (bytecnt == (((acc == ACC_BOOT) ? BOOT_BYTES : USER_BYTES) - 9'd1));

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge MCLK) begin
        if (RESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: begin
                if (start_boot) begin
                    state_n = ST_SYNC;
                end else if (start_user) begin
                    state_n = ST_WAITBYTE;
                end
            end
            ST_SYNC: begin
                if (wphase && (synccnt == SYNC_LAST)) begin
                    state_n = ST_WAITBYTE;
                end
            end
            ST_WAITBYTE: begin
                if (bus.BYTEVALID) begin
                    state_n = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (wphase && (bitcnt == 3'd7)) begin
                    state_n = last_byte ? ST_DONE : ST_WAITBYTE;
                end
            end
            ST_DONE: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output / datapath next values. Address and data for a write are
    // loaded on the edge that enters its cycle A, so they are already
    // stable when the strobe rises one cycle later.
    // ------------------------------------------------------------------
    always_comb begin
        wphase_n  = wphase;
        waddr_n   = waddr;
        wdata_n   = wdata;
        shreg_n   = shreg;
        bitcnt_n  = bitcnt;
        bytecnt_n = bytecnt;
        synccnt_n = synccnt;
        acc_n     = acc;
        wclk_n    = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start_boot || start_user) begin
                    acc_n     = bus.ACCTYPE;
                    bytecnt_n = '0;
                    synccnt_n = '0;
                    wphase_n  = 1'b0;
                    if (start_boot) begin
                        waddr_n = SYNC_FIRST_ADDR;
                        wdata_n = 1'b0;
                    end
                end
            end
            ST_SYNC: begin
                if (!wphase) begin
                    wphase_n = 1'b1;
                end else begin
                    wphase_n = 1'b0;
                    if (synccnt != SYNC_LAST) begin
                        synccnt_n = synccnt + 7'd1;
                        waddr_n   = waddr + 15'd2;
                        // Only the final sync write carries a one.
                        wdata_n   = (synccnt == (SYNC_LAST - 7'd1));
                    end
                end
            end
            ST_WAITBYTE: begin
                if (bus.BYTEVALID) begin
                    shreg_n  = bus.BYTEDATA;
                    wdata_n  = bus.BYTEDATA[0];
                    bitcnt_n = '0;
                    wphase_n = 1'b0;
                    // First byte jumps to the image base; later bytes
                    // continue from the last written bit.
                    waddr_n  = (bytecnt == 9'd0) ? base_addr : (waddr + 15'd1);
                end
            end
            ST_SHIFT: begin
                if (!wphase) begin
                    wphase_n = 1'b1;
                end else begin
                    wphase_n = 1'b0;
                    if (bitcnt != 3'd7) begin
                        bitcnt_n = bitcnt + 3'd1;
                        // Rotate so the next bit to send sits in shreg[0].
                        shreg_n  = {shreg[0], shreg[7:1]};
                        wdata_n  = shreg[1];
                        waddr_n  = waddr + 15'd1;
                    end else begin
                        bytecnt_n = bytecnt + 9'd1;
                    end
                end
            end
            default: begin
            end
        endcase

        // Strobe is registered so it is glitch-free toward the buffer.
        wclk_n = ((state_n == ST_SYNC) || (state_n == ST_SHIFT)) && wphase_n;
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge MCLK) begin
        if (RESET) begin
            wphase  <= 1'b0;
            waddr   <= '0;
            wdata   <= 1'b0;
            wclk    <= 1'b0;
            shreg   <= '0;
            bitcnt  <= '0;
            bytecnt <= '0;
            synccnt <= '0;
            acc     <= '0;
        end else begin
            wphase  <= wphase_n;
            waddr   <= waddr_n;
            wdata   <= wdata_n;
            wclk    <= wclk_n;
            shreg   <= shreg_n;
            bitcnt  <= bitcnt_n;
            bytecnt <= bytecnt_n;
            synccnt <= synccnt_n;
            acc     <= acc_n;
        end
    end

    assign bus.BYTEREADY = (state == ST_WAITBYTE);
    assign bus.LOADBUSY  = (state != ST_IDLE);
    assign bus.LOADDONE  = (state == ST_DONE);
    assign bus.BUFWADDR  = waddr;
    assign bus.BUFWDATA  = wdata;
    assign bus.BUFWCLK   = wclk;
    assign fsm_state     = state;

endmodule
